// File: rtl/nios2_qsys_dct_buffer_ctrl_if.sv
// rtl/nios2_qsys_dct_buffer_ctrl_if.sv - fragment-in / buffer-word-out bundle for the DCT buffer sequencer
interface nios2_qsys_dct_buffer_ctrl_if #(
  parameter int FRAG_W = 6,
  parameter int CNT_W  = 4
);
  logic              frag_valid;
  logic [FRAG_W-1:0] frag_data;
  logic              frag_ready;
  logic              flush_req;
  logic              test_ending;
  logic              out_valid;
  logic              out_ready;
  logic [29:0]       dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_has_ended;

  modport master (
    output frag_valid, frag_data, flush_req, test_ending, out_ready,
    input  frag_ready, out_valid, dct_buffer, dct_count, test_has_ended
  );

  modport slave (
    input  frag_valid, frag_data, flush_req, test_ending, out_ready,
    output frag_ready, out_valid, dct_buffer, dct_count, test_has_ended
  );
endinterface

// File: rtl/nios2_qsys_dct_buffer_ctrl.sv
// rtl/nios2_qsys_dct_buffer_ctrl.sv - packs trace fragments into 30-bit DCT words and sequences end-of-test drain
module nios2_qsys_dct_buffer_ctrl #(
  parameter int FRAG_W    = 6,
  parameter int MAX_FRAGS = 5,
  parameter int CNT_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  nios2_qsys_dct_buffer_ctrl_if.slave   bus_if
);

  if (FRAG_W * MAX_FRAGS != 30) begin : g_width_check
    $error("FRAG_W*MAX_FRAGS must equal 30");
  end

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_FRAGS);

  state_e           state_q, state_d;
  logic [29:0]      buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             end_latch_q, end_latch_d;

  logic             frag_ready;
  logic             out_valid;
  logic             accept;
  logic             ending_now;
  logic [CNT_W-1:0] cnt_after;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      buf_q       <= '0;
      cnt_q       <= '0;
      end_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      end_latch_q <= end_latch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    end_latch_d = end_latch_q;
    frag_ready  = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    cnt_after   = cnt_q;
    // The latch gates frag_ready, but the raw pulse already steers the state so an
    // empty buffer reaches DONE one cycle after test_ending.
    ending_now  = end_latch_q | bus_if.test_ending;

    if (state_q != DONE) begin
      end_latch_d = ending_now;
    end

    unique case (state_q)
      FILL: begin
        frag_ready = !reset && (cnt_q < MaxCnt) && !end_latch_q;
        accept     = bus_if.frag_valid && frag_ready;
        cnt_after  = cnt_q + CNT_W'(accept);
        for (int i = 0; i < MAX_FRAGS; i++) begin
          if (accept && cnt_q == CNT_W'(i)) begin
            buf_d[i*FRAG_W +: FRAG_W] = bus_if.frag_data;
          end
        end
        cnt_d = cnt_after;
        if (ending_now) begin
          state_d = (cnt_after != '0) ? DRAIN : DONE;
        end else if (cnt_after == MaxCnt) begin
          state_d = DRAIN;
        end else if (bus_if.flush_req && cnt_after != '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = !reset;
        if (out_valid && bus_if.out_ready) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ending_now ? DONE : FILL;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign bus_if.frag_ready     = frag_ready;
  assign bus_if.out_valid      = out_valid;
  assign bus_if.dct_buffer     = buf_q;
  assign bus_if.dct_count      = cnt_q;
  assign bus_if.test_has_ended = !reset && (state_q == DONE);

endmodule

// File: tb/tb_nios2_qsys_dct_buffer_ctrl.sv
// tb/tb_nios2_qsys_dct_buffer_ctrl.sv - directed self-checking bench for the DCT buffer sequencer
module tb_nios2_qsys_dct_buffer_ctrl;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  nios2_qsys_dct_buffer_ctrl_if #(.FRAG_W(6), .CNT_W(4)) bus ();

  nios2_qsys_dct_buffer_ctrl #(.FRAG_W(6), .MAX_FRAGS(5), .CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.frag_valid  = 1'b0;
    bus.frag_data   = '0;
    bus.flush_req   = 1'b0;
    bus.test_ending = 1'b0;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    check("rst_frag_ready", 32'(bus.frag_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(bus.dct_count), 32'd0);
    check("rst_buffer", 32'(bus.dct_buffer), 32'd0);
    check("rst_ended", 32'(bus.test_has_ended), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_frag_ready", 32'(bus.frag_ready), 32'd1);

    // Full word: 1 | 2<<6 | 3<<12 | 4<<18 | 5<<24 = 0x5103081
    bus.out_ready  = 1'b1;
    bus.frag_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.frag_data = 6'(i);
      #1;
      check("full_accept_ready", 32'(bus.frag_ready), 32'd1);
      tick();
    end
    bus.frag_valid = 1'b0;
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_count", 32'(bus.dct_count), 32'd5);
    check("full_buffer", 32'(bus.dct_buffer), 32'h0510_3081);
    check("full_frag_ready", 32'(bus.frag_ready), 32'd0);
    tick();
    check("full_cleared_valid", 32'(bus.out_valid), 32'd0);
    check("full_cleared_count", 32'(bus.dct_count), 32'd0);
    check("full_cleared_buffer", 32'(bus.dct_buffer), 32'd0);
    check("full_idle_ready", 32'(bus.frag_ready), 32'd1);

    // Flushed partial word under backpressure: 0x3F | 0x15<<6 = 0x57F
    bus.out_ready  = 1'b0;
    bus.frag_valid = 1'b1;
    bus.frag_data  = 6'h3F;
    tick();
    bus.frag_data  = 6'h15;
    tick();
    bus.frag_valid = 1'b0;
    bus.flush_req  = 1'b1;
    tick();
    bus.flush_req  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_buffer", 32'(bus.dct_buffer), 32'h0000_057F);
      check("bp_count", 32'(bus.dct_count), 32'd2);
      check("bp_frag_ready", 32'(bus.frag_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(bus.out_valid), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    check("bp_done_valid", 32'(bus.out_valid), 32'd0);
    check("bp_done_count", 32'(bus.dct_count), 32'd0);

    // Flush on an empty buffer is ignored
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    check("empty_flush_valid", 32'(bus.out_valid), 32'd0);
    check("empty_flush_ready", 32'(bus.frag_ready), 32'd1);
    tick();
    check("empty_flush_valid2", 32'(bus.out_valid), 32'd0);

    // End of test with 3 fragments: 0x0A | 0x0B<<6 | 0x0C<<12 = 0xC2CA
    bus.frag_valid = 1'b1;
    bus.frag_data  = 6'h0A;
    tick();
    bus.frag_data  = 6'h0B;
    tick();
    bus.frag_data  = 6'h0C;
    tick();
    bus.frag_valid  = 1'b0;
    bus.test_ending = 1'b1;
    #1;
    check("end_ready_before_latch", 32'(bus.frag_ready), 32'd1);
    tick();
    bus.test_ending = 1'b0;
    check("end_drain_valid", 32'(bus.out_valid), 32'd1);
    check("end_drain_count", 32'(bus.dct_count), 32'd3);
    check("end_drain_buffer", 32'(bus.dct_buffer), 32'h0000_C2CA);
    check("end_drain_ready", 32'(bus.frag_ready), 32'd0);
    check("end_not_yet_ended", 32'(bus.test_has_ended), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("end_ended", 32'(bus.test_has_ended), 32'd1);
    check("end_valid_low", 32'(bus.out_valid), 32'd0);
    bus.frag_valid = 1'b1;
    bus.flush_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_sticky", 32'(bus.test_has_ended), 32'd1);
      check("done_frag_ready", 32'(bus.frag_ready), 32'd0);
      check("done_out_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.frag_valid = 1'b0;
    bus.flush_req  = 1'b0;
    bus.out_ready  = 1'b0;

    // End of test with empty buffer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("empty_end_pre", 32'(bus.test_has_ended), 32'd0);
    bus.test_ending = 1'b1;
    tick();
    bus.test_ending = 1'b0;
    check("empty_end_ended", 32'(bus.test_has_ended), 32'd1);
    check("empty_end_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("empty_end_valid2", 32'(bus.out_valid), 32'd0);

    // test_ending together with an accept: fragment is kept and drained
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.frag_valid  = 1'b1;
    bus.frag_data   = 6'h21;
    bus.test_ending = 1'b1;
    #1;
    check("simul_ready", 32'(bus.frag_ready), 32'd1);
    tick();
    bus.frag_valid  = 1'b0;
    bus.test_ending = 1'b0;
    check("simul_valid", 32'(bus.out_valid), 32'd1);
    check("simul_count", 32'(bus.dct_count), 32'd1);
    check("simul_buffer", 32'(bus.dct_buffer), 32'h0000_0021);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("simul_ended", 32'(bus.test_has_ended), 32'd1);

    // Reset in the middle of a drain discards the word
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.frag_valid = 1'b1;
    bus.frag_data  = 6'h11;
    tick();
    bus.frag_data  = 6'h22;
    bus.flush_req  = 1'b1;
    tick();
    bus.frag_valid = 1'b0;
    bus.flush_req  = 1'b0;
    check("mid_drain_valid", 32'(bus.out_valid), 32'd1);
    check("mid_drain_count", 32'(bus.dct_count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_count", 32'(bus.dct_count), 32'd0);
    check("post_rst_buffer", 32'(bus.dct_buffer), 32'd0);
    check("post_rst_ended", 32'(bus.test_has_ended), 32'd0);
    check("post_rst_ready", 32'(bus.frag_ready), 32'd1);
    tick();
    check("post_rst_valid2", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
